// File: rtl/pll_lock_controller.sv
// PLL reset/lock sequencer: holds the PLL in reset, waits for a stable lock, and retries or falls back on timeout.
// Optional macro PLL_LOCK_CONTROLLER_BYPASS_FALLBACK_EN selects BYPASS instead of FAIL as the fallback state.
module pll_lock_controller #(
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned LOCK_STABLE  = 256,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic       REFERENCECLK,
  input  logic       RESET,
  input  logic       LOCK,
  input  logic       FORCE_BYPASS,
  output logic       PLL_RESETB,
  output logic       PLL_BYPASS,
  output logic       SYS_RESETN,
  output logic       LOCKED,
  output logic       FAILED,
  output logic [3:0] RETRY_CNT,
  output logic [2:0] dbg_state
);

  localparam logic [15:0] HOLD_LEN    = 16'(RESET_CYCLES);
  localparam logic [15:0] STABLE_LEN  = 16'(LOCK_STABLE);
  localparam logic [15:0] TIMEOUT_LEN = 16'(LOCK_TIMEOUT);
  localparam logic [3:0]  RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RUN       = 3'd2,
`ifdef PLL_LOCK_CONTROLLER_BYPASS_FALLBACK_EN
    ST_BYPASS    = 3'd3
`else
    ST_FAIL      = 3'd4
`endif
  } state_t;

`ifdef PLL_LOCK_CONTROLLER_BYPASS_FALLBACK_EN
  localparam state_t ST_FALLBACK = ST_BYPASS;
`else
  localparam state_t ST_FALLBACK = ST_FAIL;
  logic unused_force_bypass;
  assign unused_force_bypass = FORCE_BYPASS;
`endif

  state_t      state_q, state_d;
  logic        lock_meta_q, lock_sync_q;
  logic [15:0] cycle_cnt_q, cycle_cnt_d;
  logic [15:0] stable_cnt_q, stable_cnt_d;
  logic [3:0]  retry_cnt_q, retry_cnt_d;
  logic        failed_q, failed_d;
  logic        pll_resetb_q, pll_resetb_d;
  logic        pll_bypass_q, pll_bypass_d;
  logic        sys_resetn_q, sys_resetn_d;
  logic        locked_q, locked_d;
  logic [15:0] cycle_inc, stable_inc;
  logic [3:0]  retry_inc;

  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= ST_HOLD;
      lock_meta_q  <= 1'b0;
      lock_sync_q  <= 1'b0;
      cycle_cnt_q  <= 16'd0;
      stable_cnt_q <= 16'd0;
      retry_cnt_q  <= 4'd0;
      failed_q     <= 1'b0;
      pll_resetb_q <= 1'b0;
      pll_bypass_q <= 1'b0;
      sys_resetn_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_meta_q  <= LOCK;
      lock_sync_q  <= lock_meta_q;
      cycle_cnt_q  <= cycle_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
      failed_q     <= failed_d;
      pll_resetb_q <= pll_resetb_d;
      pll_bypass_q <= pll_bypass_d;
      sys_resetn_q <= sys_resetn_d;
      locked_q     <= locked_d;
    end
  end

  // Transitions fire on the edge where a counter would reach its limit, so
  // HOLD lasts exactly RESET_CYCLES and RUN follows LOCK by 2+LOCK_STABLE.
  always_comb begin
    state_d      = state_q;
    cycle_cnt_d  = cycle_cnt_q;
    stable_cnt_d = stable_cnt_q;
    retry_cnt_d  = retry_cnt_q;
    failed_d     = failed_q;
    cycle_inc    = cycle_cnt_q + 16'd1;
    stable_inc   = lock_sync_q ? (stable_cnt_q + 16'd1) : 16'd0;
    retry_inc    = retry_cnt_q + 4'd1;

    unique case (state_q)
      ST_HOLD: begin
        if (cycle_inc == HOLD_LEN) begin
          state_d      = ST_WAIT_LOCK;
          cycle_cnt_d  = 16'd0;
          stable_cnt_d = 16'd0;
        end else begin
          cycle_cnt_d  = cycle_inc;
        end
      end
      ST_WAIT_LOCK: begin
        // Stable completion wins a tie with the timeout.
        if (stable_inc == STABLE_LEN) begin
          state_d      = ST_RUN;
          cycle_cnt_d  = 16'd0;
          stable_cnt_d = 16'd0;
          retry_cnt_d  = 4'd0;
        end else if (cycle_inc == TIMEOUT_LEN) begin
          retry_cnt_d  = retry_inc;
          cycle_cnt_d  = 16'd0;
          stable_cnt_d = 16'd0;
          if (retry_inc < RETRY_LIMIT) begin
            state_d = ST_HOLD;
          end else begin
            state_d  = ST_FALLBACK;
            failed_d = 1'b1;
          end
        end else begin
          cycle_cnt_d  = cycle_inc;
          stable_cnt_d = stable_inc;
        end
      end
      ST_RUN: begin
        retry_cnt_d = 4'd0;
        if (!lock_sync_q) begin
          state_d      = ST_HOLD;
          cycle_cnt_d  = 16'd0;
          stable_cnt_d = 16'd0;
        end
      end
      ST_FALLBACK: begin
        state_d = ST_FALLBACK;
      end
      default: begin
        state_d      = ST_HOLD;
        cycle_cnt_d  = 16'd0;
        stable_cnt_d = 16'd0;
      end
    endcase

`ifdef PLL_LOCK_CONTROLLER_BYPASS_FALLBACK_EN
    // A forced bypass overrides everything and never marks the PLL as failed.
    if (FORCE_BYPASS && (state_q != ST_BYPASS)) begin
      state_d      = ST_BYPASS;
      cycle_cnt_d  = 16'd0;
      stable_cnt_d = 16'd0;
      retry_cnt_d  = retry_cnt_q;
      failed_d     = failed_q;
    end
`endif
  end

  always_comb begin
    pll_resetb_d = 1'b0;
    pll_bypass_d = 1'b0;
    sys_resetn_d = 1'b0;
    locked_d     = 1'b0;
    case (state_d)
      ST_WAIT_LOCK: begin
        pll_resetb_d = 1'b1;
      end
      ST_RUN: begin
        pll_resetb_d = 1'b1;
        sys_resetn_d = 1'b1;
        locked_d     = 1'b1;
      end
`ifdef PLL_LOCK_CONTROLLER_BYPASS_FALLBACK_EN
      ST_BYPASS: begin
        // System reset releases one cycle after the bypass mux has switched.
        pll_resetb_d = 1'b1;
        pll_bypass_d = 1'b1;
        sys_resetn_d = (state_q == ST_BYPASS);
      end
`endif
      default: begin
        pll_resetb_d = 1'b0;
      end
    endcase
  end

  assign PLL_RESETB = pll_resetb_q;
  assign PLL_BYPASS = pll_bypass_q;
  assign SYS_RESETN = sys_resetn_q;
  assign LOCKED     = locked_q;
  assign FAILED     = failed_q;
  assign RETRY_CNT  = retry_cnt_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/pll_lock_controller.md
PLL_LOCK_CONTROLLER -- requirements
Module: pll_lock_controller

Interface
REQ-001 Parameter RESET_CYCLES, 16: number of cycles PLL_RESETB is held low per attempt (range 1..65535).
REQ-002 Parameter LOCK_STABLE, 256: consecutive synchronized LOCK-high cycles required before lock is declared (range 1..65535).
REQ-003 Parameter LOCK_TIMEOUT, 4096: maximum WAIT_LOCK cycles per attempt (range greater than LOCK_STABLE, up to 65535).
REQ-004 Parameter MAX_RETRIES, 3: number of failed attempts before fallback (range 1..15).
REQ-005 REFERENCECLK  input  1  controller clock, the same free-running reference clock that feeds the PLL.
REQ-006 RESET  input  1  asynchronous, active-low reset.
REQ-007 LOCK  input  1  PLL lock indication, asynchronous to REFERENCECLK.
REQ-008 FORCE_BYPASS  input  1  level request to run from the reference clock through the PLL bypass.
REQ-009 PLL_RESETB  output  1  active-low reset driven to the PLL.
REQ-010 PLL_BYPASS  output  1  bypass select driven to the PLL.
REQ-011 SYS_RESETN  output  1  active-low system reset for logic clocked by the PLL output.
REQ-012 LOCKED  output  1  high in RUN only.
REQ-013 FAILED  output  1  sticky; high after MAX_RETRIES consecutive timeouts.
REQ-014 RETRY_CNT  output  4  count of consecutive failed attempts.

Function
REQ-015 LOCK SHALL pass through a 2-flop synchronizer; all LOCK references below mean the synchronized value.
REQ-016 The FSM SHALL have the states HOLD, WAIT_LOCK, RUN, BYPASS and FAIL; all outputs SHALL be registered.
REQ-017 HOLD: PLL_RESETB=0 and SYS_RESETN=0 for exactly RESET_CYCLES cycles, then go to WAIT_LOCK.
REQ-018 WAIT_LOCK: PLL_RESETB=1; the stable counter increments while LOCK=1 and clears to 0 on LOCK=0; the timeout counter increments every cycle.
REQ-019 When the stable counter reaches LOCK_STABLE, go to RUN; from the LOCK rising edge to SYS_RESETN high is 2+LOCK_STABLE cycles.
REQ-020 When the timeout counter reaches LOCK_TIMEOUT without a transition to RUN, increment RETRY_CNT; if RETRY_CNT is then below MAX_RETRIES go to HOLD, otherwise go to the fallback state (REQ-027/028).
REQ-021 If stable completion and timeout occur in the same cycle, RUN SHALL take priority and RETRY_CNT SHALL be unchanged.
REQ-022 RUN: SYS_RESETN=1, LOCKED=1, RETRY_CNT cleared to 0.
REQ-023 LOCK=0 in RUN SHALL drive SYS_RESETN=0 and LOCKED=0 on the next clock edge and move to HOLD; a lock loss SHALL NOT increment RETRY_CNT.
REQ-024 Both counters SHALL clear on every entry to HOLD and to WAIT_LOCK; no counter SHALL wrap.

Reset
REQ-025 While RESET=0: state=HOLD, PLL_RESETB=0, PLL_BYPASS=0, SYS_RESETN=0, LOCKED=0, FAILED=0, RETRY_CNT=0, all counters and synchronizer flops 0.
REQ-026 Asserting RESET mid-operation, including from BYPASS or FAIL, SHALL return every output to its reset value immediately; after release, a full HOLD period SHALL start.

Configuration
REQ-027 Macro PLL_LOCK_CONTROLLER_BYPASS_FALLBACK_EN defined: the fallback state is BYPASS (PLL_BYPASS=1, PLL_RESETB=1, SYS_RESETN=1 one cycle after entry, LOCKED=0, FAILED=1 when entered via retries); FORCE_BYPASS=1 in any state SHALL enter BYPASS on the next edge without setting FAILED; BYPASS is left only by RESET.
REQ-028 Macro not defined: the fallback state is FAIL (PLL_RESETB=0, PLL_BYPASS=0, SYS_RESETN=0, FAILED=1, held until RESET); FORCE_BYPASS is ignored; the BYPASS state is not generated.

Verification (RESET_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRIES=2)
REQ-029 Release RESET; LOCK rises 10 cycles later and stays high -> PLL_RESETB high 4 cycles after release; SYS_RESETN and LOCKED rise exactly 10 cycles after the LOCK edge; RETRY_CNT=0.
REQ-030 LOCK toggles high 5 cycles / low 1 cycle repeatedly -> no RUN entry; timeout at 32 cycles; RETRY_CNT=1; PLL_RESETB low again for 4 cycles.
REQ-031 LOCK held low -> after two timeouts RETRY_CNT=2 and FAILED=1; with the macro: PLL_BYPASS=1 and SYS_RESETN=1; without the macro: PLL_RESETB=0 and SYS_RESETN=0 persisting for 1000 cycles.
REQ-032 In RUN, pulse LOCK low for 3 cycles -> SYS_RESETN low within 3 cycles of the falling edge; HOLD for 4 cycles; relock after 2+8 cycles of stable LOCK; RETRY_CNT stays 0.
REQ-033 Align LOCK so that stable count reaches 8 on timeout cycle 32 -> RUN entered and RETRY_CNT unchanged.
REQ-034 With the macro, assert FORCE_BYPASS in WAIT_LOCK -> BYPASS on the next edge with FAILED=0; then assert RESET -> all outputs return to reset values asynchronously.
